lim_ramp_sched: RTL

LIM_RAMP_SCHED -- requirements
Module: lim_ramp_sched

---
 rtl/lim_ramp_sched_if.sv | 34 +++
 rtl/lim_ramp_sched.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/lim_ramp_sched_if.sv
// lim_ramp_sched_if: control and status bundle of the limit ramp scheduler.
// master drives ramp/monitor inputs, slave returns limit and saturation status.
interface lim_ramp_sched_if #(
    parameter int RES   = 14,
    parameter int PER_W = 16,
    parameter int CNT_W = 16
);
    logic                    start;
    logic                    abort;
    logic        [RES-1:0]   lim_init;
    logic        [RES-1:0]   lim_tgt;
    logic        [PER_W-1:0] period;
    logic        [CNT_W-1:0] sat_max;
    logic signed [RES-1:0]   in;
    logic                    clr_alarm;
    logic        [RES-1:0]   lim;
    logic                    busy;
    logic                    done;
    logic                    sat;
    logic        [CNT_W-1:0] sat_cnt;
    logic                    alarm;

    modport master (
        output start, abort, lim_init, lim_tgt, period,
        output sat_max, in, clr_alarm,
        input  lim, busy, done, sat, sat_cnt, alarm
    );

    modport slave (
        input  start, abort, lim_init, lim_tgt, period,
        input  sat_max, in, clr_alarm,
        output lim, busy, done, sat, sat_cnt, alarm
    );
endinterface

// File: rtl/lim_ramp_sched.sv
// lim_ramp_sched: steps a saturator limit exponent toward a target and tracks saturation runs.
// Define LIM_SAT_ALARM_STICKY_EN to make the alarm latch until clr_alarm.
module lim_ramp_sched #(
    parameter int RES   = 14,
    parameter int PER_W = 16,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    lim_ramp_sched_if.slave    bus
);
    localparam int             LMAX_I = RES - 1;
    localparam logic [RES-1:0] LMAX   = LMAX_I[RES-1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nxt_state;
    logic [RES-1:0]   r_lim;
    logic [RES-1:0]   w_nxt_lim;
    logic [PER_W-1:0] r_cnt;
    logic [PER_W-1:0] w_nxt_cnt;
    logic             r_done;
    logic             w_nxt_done;
    logic             w_busy;
    logic [RES-1:0]   w_init_c;
    logic [RES-1:0]   w_tgt_c;
    logic [RES-1:0]   w_in_u;
    logic [RES-1:0]   w_pos_sh;
    logic [RES-1:0]   w_neg_sh;
    logic             w_sat;
    logic             r_sat;
    logic [CNT_W-1:0] r_sat_cnt;
    logic             w_alarm_cond;
    logic             r_alarm;

    assign w_init_c = (bus.lim_init > LMAX) ? LMAX : bus.lim_init;
    assign w_tgt_c  = (bus.lim_tgt > LMAX) ? LMAX : bus.lim_tgt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_lim   <= LMAX;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_lim   <= w_nxt_lim;
            r_cnt   <= w_nxt_cnt;
            r_done  <= w_nxt_done;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_lim   = r_lim;
        w_nxt_cnt   = r_cnt;
        w_nxt_done  = 1'b0;
        if (bus.abort) begin
            w_nxt_state = IDLE;
            w_nxt_cnt   = '0;
        end else if (bus.start) begin
            w_nxt_state = RAMP;
            w_nxt_lim   = w_init_c;
            w_nxt_cnt   = '0;
        end else begin
            unique case (r_state)
                RAMP: begin
                    if (r_lim == w_tgt_c) begin
                        w_nxt_state = HOLD;
                        w_nxt_done  = 1'b1;
                    end else if (r_cnt == bus.period) begin
                        w_nxt_cnt = '0;
                        w_nxt_lim = (r_lim < w_tgt_c) ? r_lim + 1'b1
                                                      : r_lim - 1'b1;
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (w_tgt_c != r_lim) begin
                        w_nxt_state = RAMP;
                        w_nxt_cnt   = '0;
                    end
                end
                IDLE: begin
                    w_nxt_state = IDLE;
                end
                default: begin
                    w_nxt_state = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_busy = (r_state == RAMP);
    end

    // Any bit surviving the shift means |in| does not fit the current lim.
    assign w_in_u   = bus.in;
    assign w_pos_sh = w_in_u >> r_lim;
    assign w_neg_sh = (~w_in_u) >> r_lim;
    assign w_sat    = w_in_u[RES-1] ? (w_neg_sh != '0) : (w_pos_sh != '0);

    assign w_alarm_cond = (bus.sat_max != '0) && (r_sat_cnt >= bus.sat_max);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat     <= 1'b0;
            r_sat_cnt <= '0;
        end else begin
            r_sat <= w_sat;
            if (!r_sat) begin
                r_sat_cnt <= '0;
            end else if (!(&r_sat_cnt)) begin
                r_sat_cnt <= r_sat_cnt + 1'b1;
            end
        end
    end

`ifdef LIM_SAT_ALARM_STICKY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alarm <= 1'b0;
        end else begin
            r_alarm <= w_alarm_cond | (r_alarm & ~bus.clr_alarm);
        end
    end
`else
    logic w_unused_clr;
    assign w_unused_clr = bus.clr_alarm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alarm <= 1'b0;
        end else begin
            r_alarm <= w_alarm_cond;
        end
    end
`endif

    assign bus.lim     = r_lim;
    assign bus.busy    = w_busy;
    assign bus.done    = r_done;
    assign bus.sat     = r_sat;
    assign bus.sat_cnt = r_sat_cnt;
    assign bus.alarm   = r_alarm;
endmodule
